lsu_master: RTL
===============

# lsu_master

Load/store initiator that drives the word-addressed memory map (instruction ROM and data RAM) on behalf of the core. It accepts one byte, halfword or word request at a time, rejects misaligned accesses, and performs read-modify-write for sub-word stores because the memory port is word-wide only. For loads it extracts and sign- or zero-extends the addressed lane and returns it with a single-cycle response pulse.

## Interface
- DATA_WIDTH, default 32: data bus width; fixed at 32 for lane logic.
- ADDR_WIDTH, default 32: byte address width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access, valid with rsp_valid.
- mem_A  out  ADDR_WIDTH  word-aligned address to memory map, bits [1:0] always 0.
- mem_WD  out  DATA_WIDTH  write data.
- mem_re  out  1  read strobe.
- mem_we  out  1  write enable, sampled by memory at the rising clk edge.
- mem_RD  in  DATA_WIDTH  combinational read data for the current mem_A.

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields and go to:
  - RESP with err=1 if misaligned (half with addr[0]=1; word with addr[1:0]!=0).
  - RD for loads.
  - WR for word stores.
  - RMW_RD for byte/half stores.
- RD: mem_A={addr[31:2],00}, mem_re=1. Capture the extracted lane from mem_RD, then go to RESP.
- RMW_RD: same drive as RD. Capture the full word, then go to WR.
- WR: mem_we=1, mem_WD = word store data, or the captured word with the addressed lane replaced. Go to RESP.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err driven from registers. Return to IDLE.
- Lanes are little-endian: byte k occupies bits [8k+7:8k] where k=addr[1:0]; halfword j occupies bits [16j+15:16j] where j=addr[1].
- Sign extension replicates bit 7 or bit 15 unless req_unsigned is set.
- Outside their states, mem_re, mem_we, mem_A and mem_WD are 0.
- Responses have no backpressure. The consumer must accept rsp_valid in the cycle it is asserted.

## Timing
- Reset values: state IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_* all 0.
- Latency from the accept edge to the rsp_valid cycle:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- The write commits at the edge that ends WR.
- req_ready is low from the accept edge until the state returns to IDLE. The earliest next accept is the edge ending the cycle after RESP, so there is no overlap.
- Reset asserted mid-operation: all outputs clear immediately (combinational from asynchronous state reset). A store aborted before the WR edge leaves memory unchanged, and no response is issued.
- req_* changes while busy are ignored.

## Structure
- Package lsu_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state enum
  - misalignment check function
- Sub-module lsu_lane_merge (combinational):
  - inputs: word, addr[1:0], size, wdata, unsigned
  - outputs: merged store word, extended load value
- The FSM and registers live in lsu_master.

## Test plan
- Word store 0xDEADBEEF to 0x10010000, then word load → mem_we for exactly one cycle; rsp_rdata=0xDEADBEEF; 2-cycle latency each.
- Byte store 0xAB to 0x10010002 → RAM word becomes 0xDEABBEEF in 3 cycles. Then lb → 0xFFFFFFAB; lbu → 0x000000AB.
- Half store 0x1234 to 0x10010002 → 0x1234BEEF. Then lh at 0x10010000 → 0xFFFFBEEF; lhu at 0x10010002 → 0x00001234.
- lw at 0x10010001 and sh at 0x10010003 → rsp_err=1 one cycle after accept; mem_re and mem_we never assert; memory unchanged.
- Load from ROM at 0x00400004 → rsp_rdata equals ROM word 1. Also: req_valid held high across two requests → second accepted only after RESP; req_ready=0 throughout.
- rst pulled low during the RMW_RD cycle of a byte store → mem_re drops immediately; rsp_valid never pulses; RAM word unchanged; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and the alignment rule for the load/store initiator.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RMW_RD,
      S_WR,
      S_RESP
   } lsu_state_e;

   // Size 2'b11 falls into the word rule.
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return addr[0];
         default: return addr != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Little-endian lane logic: inserts store data into a word and extracts/extends a load lane.
module lsu_lane_merge
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic        unsigned_i,
   output logic [31:0] store_word_o,
   output logic [31:0] load_val_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane    = word_i[{addr_i, 3'b000} +: 8];
      half_lane    = word_i[{addr_i[1], 4'b0000} +: 16];
      store_word_o = word_i;
      load_val_o   = word_i;
      case (size_i)
         SZ_BYTE: begin
            store_word_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
            load_val_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
         end
         SZ_HALF: begin
            store_word_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            load_val_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
         end
         default: begin
            store_word_o = wdata_i;
            load_val_o   = word_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator: one request at a time, misalignment rejection, read-modify-write
// for sub-word stores over a word-wide memory port.
module lsu_master
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_A,
   output logic [DATA_WIDTH-1:0] mem_WD,
   output logic                  mem_re,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_RD
);

   lsu_state_e            state_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] word_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic [DATA_WIDTH-1:0] lane_word;
   logic [DATA_WIDTH-1:0] store_word;
   logic [DATA_WIDTH-1:0] load_val;

   // In WR the merge works on the word captured during RMW_RD; otherwise on live read data.
   assign lane_word = (state_q == S_WR) ? word_q : mem_RD;

   lsu_lane_merge u_lane (
      .word_i       (lane_word),
      .addr_i       (addr_q[1:0]),
      .size_i       (size_q),
      .wdata_i      (wdata_q),
      .unsigned_i   (uns_q),
      .store_word_o (store_word),
      .load_val_o   (load_val)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  rdata_q <= '0;
                  err_q   <= lsu_misaligned(req_size, req_addr[1:0]);
                  if (lsu_misaligned(req_size, req_addr[1:0]))
                     state_q <= S_RESP;
                  else if (!req_we)
                     state_q <= S_RD;
                  else if (req_size == SZ_BYTE || req_size == SZ_HALF)
                     state_q <= S_RMW_RD;
                  else
                     state_q <= S_WR;
               end
            end
            S_RD: begin
               rdata_q <= load_val;
               state_q <= S_RESP;
            end
            S_RMW_RD: begin
               word_q  <= mem_RD;
               state_q <= S_WR;
            end
            S_WR:    state_q <= S_RESP;
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs decode the registered state, so an asynchronous reset clears them at once.
   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign rsp_err   = rsp_valid & err_q;
   assign mem_re    = (state_q == S_RD) || (state_q == S_RMW_RD);
   assign mem_we    = (state_q == S_WR);
   assign mem_A     = (mem_re || mem_we) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_WD    = mem_we ? store_word : '0;

endmodule
